fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_seq_ctrl_pkg.sv | 31 +++
 rtl/fir_seq_ctrl_if.sv | 48 ++++
 rtl/fir_coef_bank.sv | 52 +++++
 rtl/fir_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fir_seq_ctrl_pkg
// Shared constants and types for the FIR sequencing controller:
//   N_TAPS    - number of filter coefficients (FIR_B0..FIR_B10)
//   COEF_W    - coefficient width
//   DATA_W    - sample width
//   FLUSH_LEN - zero samples pushed into the filter at end of frame when the
//               FIR_SEQ_CTRL_FLUSH_EN build option is defined
//   state_e   - controller state encoding
// -----------------------------------------------------------------------------
package fir_seq_ctrl_pkg;

    localparam int N_TAPS    = 11;
    localparam int COEF_W    = 9;
    localparam int DATA_W    = 16;
    localparam int FLUSH_LEN = 11;
    localparam int ADDR_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Coefficient index is legal only inside the tap range.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(N_TAPS);
    endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// fir_seq_ctrl_if
// Bundles every non-clock/reset signal of fir_seq_ctrl.
//   master modport : the environment (config port, upstream source, filter)
//   slave modport  : the controller itself
// Groups: coefficient config (CFG_*), frame control (START/FRAME_LEN/BUSY/
// DONE/TIMEOUT/CFG_ERR), upstream handshake (SRC_*), filter side (FIR_*).
// -----------------------------------------------------------------------------
interface fir_seq_ctrl_if #(
    parameter int FRAME_W = 10
);
    import fir_seq_ctrl_pkg::*;

    logic                 CFG_WE;
    logic [ADDR_W-1:0]    CFG_ADDR;
    logic [COEF_W-1:0]    CFG_DATA;
    logic                 START;
    logic [FRAME_W-1:0]   FRAME_LEN;
    logic [DATA_W-1:0]    SRC_DIN;
    logic                 SRC_VIN;
    logic                 SRC_RDY;
    logic [DATA_W-1:0]    FIR_DIN;
    logic                 FIR_VIN;
    logic [COEF_W-1:0]    FIR_B0, FIR_B1, FIR_B2, FIR_B3, FIR_B4, FIR_B5;
    logic [COEF_W-1:0]    FIR_B6, FIR_B7, FIR_B8, FIR_B9, FIR_B10;
    logic                 FIR_VOUT;
    logic                 BUSY;
    logic                 DONE;
    logic                 CFG_ERR;
    logic                 TIMEOUT;

    modport master (
        output CFG_WE, CFG_ADDR, CFG_DATA, START, FRAME_LEN,
        output SRC_DIN, SRC_VIN, FIR_VOUT,
        input  SRC_RDY, FIR_DIN, FIR_VIN, BUSY, DONE, CFG_ERR, TIMEOUT,
        input  FIR_B0, FIR_B1, FIR_B2, FIR_B3, FIR_B4, FIR_B5,
        input  FIR_B6, FIR_B7, FIR_B8, FIR_B9, FIR_B10
    );

    modport slave (
        input  CFG_WE, CFG_ADDR, CFG_DATA, START, FRAME_LEN,
        input  SRC_DIN, SRC_VIN, FIR_VOUT,
        output SRC_RDY, FIR_DIN, FIR_VIN, BUSY, DONE, CFG_ERR, TIMEOUT,
        output FIR_B0, FIR_B1, FIR_B2, FIR_B3, FIR_B4, FIR_B5,
        output FIR_B6, FIR_B7, FIR_B8, FIR_B9, FIR_B10
    );

endinterface

// File: rtl/fir_coef_bank.sv
// -----------------------------------------------------------------------------
// fir_coef_bank
// Coefficient register file with address decode.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   we_i           : write strobe
//   wr_en_i        : writes allowed (controller idle)
//   addr_i, data_i : coefficient index and value
//   coef_o         : all coefficients, registered
//   err_o          : one-cycle pulse, the cycle after a rejected write
// -----------------------------------------------------------------------------
module fir_coef_bank
    import fir_seq_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [COEF_W-1:0] data_i,
    output logic [COEF_W-1:0] coef_o [N_TAPS],
    output logic              err_o
);

    logic              wr_ok;
    logic              err_q;
    logic [COEF_W-1:0] coef_q [N_TAPS];

    assign wr_ok = we_i && wr_en_i && addr_legal(addr_i);

    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                coef_q[gi] <= '0;
            end else if (wr_ok && (addr_i == ADDR_W'(gi))) begin
                coef_q[gi] <= data_i;
            end
        end
        assign coef_o[gi] = coef_q[gi];
    end

    // Any strobe that does not land in a register is flagged.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= we_i && !wr_ok;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fir_seq_ctrl
// Frame sequencer in front of an 11-tap FIR: accepts FRAME_LEN samples from
// upstream, forwards them one cycle later to the filter, counts filter
// outputs and finishes the frame when all outputs are back or the filter
// stays silent for DRAIN_TIMEOUT cycles.
//   CLK, RST_n : clock, asynchronous active-low reset
//   bus        : fir_seq_ctrl_if.slave (config, frame control, SRC_*, FIR_*)
// Parameters: DRAIN_TIMEOUT (silent-cycle limit in DRAIN), FRAME_W.
// Build option FIR_SEQ_CTRL_FLUSH_EN: after the last sample, push FLUSH_LEN
// zero samples into the filter and expect FRAME_LEN+FLUSH_LEN outputs.
// -----------------------------------------------------------------------------
module fir_seq_ctrl
    import fir_seq_ctrl_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 64,
    parameter int FRAME_W       = 10
) (
    input  logic          CLK,
    input  logic          RST_n,
    fir_seq_ctrl_if.slave bus
);

    localparam int TO_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int CNT_W = FRAME_W + 1;
`ifdef FIR_SEQ_CTRL_FLUSH_EN
    localparam int EXTRA = FLUSH_LEN;
`else
    localparam int EXTRA = 0;
`endif

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] len_q, in_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d, target;
    logic [TO_W-1:0]    idle_q;
    logic               rdy_q, vin_q, timeout_q;
    logic [DATA_W-1:0]  din_q;
    logic               start_ok, accept, last_in, idle_hit, flushing, set_timeout;
    logic [COEF_W-1:0]  coef [N_TAPS];

    assign start_ok = (state_q == ST_IDLE) && bus.START;
    assign accept   = (state_q == ST_RUN) && rdy_q && bus.SRC_VIN;
    assign last_in  = accept && ((in_cnt_q + FRAME_W'(1)) == len_q);
    assign target   = {1'b0, len_q} + CNT_W'(EXTRA);
    assign idle_hit = (state_q == ST_DRAIN) && !bus.FIR_VOUT &&
                      (idle_q == TO_W'(DRAIN_TIMEOUT - 1));

`ifdef FIR_SEQ_CTRL_FLUSH_EN
    logic [3:0] flush_q;

    // Loaded on the RUN->DRAIN edge; each nonzero cycle injects one zero.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            flush_q <= '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_DRAIN)) begin
            flush_q <= 4'(FLUSH_LEN);
        end else if (flush_q != '0) begin
            flush_q <= flush_q - 4'd1;
        end
    end
    assign flushing = (flush_q != '0);
`else
    assign flushing = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        out_cnt_d   = out_cnt_q;
        set_timeout = 1'b0;
        if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && bus.FIR_VOUT &&
            (out_cnt_q < target)) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = (bus.FRAME_LEN == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_in) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Count includes this cycle's output so DONE follows the last one directly.
                if (!flushing && (out_cnt_d >= target)) begin
                    state_d = ST_DONE;
                end else if (idle_hit) begin
                    state_d     = ST_DONE;
                    set_timeout = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            idle_q    <= '0;
            rdy_q     <= 1'b0;
            vin_q     <= 1'b0;
            din_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Registered ready: falls on the same edge that takes the last sample.
            rdy_q   <= (state_d == ST_RUN);
            if (start_ok) begin
                len_q     <= bus.FRAME_LEN;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (accept) begin
                    in_cnt_q <= in_cnt_q + FRAME_W'(1);
                end
                out_cnt_q <= out_cnt_d;
                if (set_timeout) begin
                    timeout_q <= 1'b1;
                end
            end
            if ((state_q == ST_DRAIN) && !bus.FIR_VOUT) begin
                idle_q <= idle_q + TO_W'(1);
            end else begin
                idle_q <= '0;
            end
            if (accept) begin
                din_q <= bus.SRC_DIN;
                vin_q <= 1'b1;
            end else if (flushing) begin
                din_q <= '0;
                vin_q <= 1'b1;
            end else begin
                vin_q <= 1'b0;
            end
        end
    end

    // Writes are only legal while idle, which keeps coefficients frozen for a frame.
    fir_coef_bank u_coef (
        .clk_i   (CLK),
        .rst_n_i (RST_n),
        .we_i    (bus.CFG_WE),
        .wr_en_i (state_q == ST_IDLE),
        .addr_i  (bus.CFG_ADDR),
        .data_i  (bus.CFG_DATA),
        .coef_o  (coef),
        .err_o   (bus.CFG_ERR)
    );

    assign bus.SRC_RDY = rdy_q;
    assign bus.FIR_DIN = din_q;
    assign bus.FIR_VIN = vin_q;
    assign bus.BUSY    = (state_q != ST_IDLE);
    assign bus.DONE    = (state_q == ST_DONE);
    assign bus.TIMEOUT = timeout_q;
    assign bus.FIR_B0  = coef[0];
    assign bus.FIR_B1  = coef[1];
    assign bus.FIR_B2  = coef[2];
    assign bus.FIR_B3  = coef[3];
    assign bus.FIR_B4  = coef[4];
    assign bus.FIR_B5  = coef[5];
    assign bus.FIR_B6  = coef[6];
    assign bus.FIR_B7  = coef[7];
    assign bus.FIR_B8  = coef[8];
    assign bus.FIR_B9  = coef[9];
    assign bus.FIR_B10 = coef[10];

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_seq_ctrl
// Scoreboard bench for fir_seq_ctrl. The stimulus process pushes the expected
// FIR_DIN/edge pairs, DONE edges and CFG_ERR edges into queues; a monitor on
// the falling edge pops and compares whenever FIR_VIN, DONE or CFG_ERR is seen.
// Edges are numbered by a counter stepped on every rising clock edge.
// Build option FIR_SEQ_CTRL_FLUSH_EN adds the zero-flush expectations.
// -----------------------------------------------------------------------------
module tb_fir_seq_ctrl;
    import fir_seq_ctrl_pkg::*;

    localparam int FW = 10;
`ifdef FIR_SEQ_CTRL_FLUSH_EN
    localparam int FL = 11;
`else
    localparam int FL = 0;
`endif

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    fir_seq_ctrl_if #(.FRAME_W(FW)) bus ();

    fir_seq_ctrl #(.DRAIN_TIMEOUT(64), .FRAME_W(FW)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    logic vout_model = 1'b0;
    logic vout_man = 1'b0;
    assign bus.FIR_VOUT = vout_model | vout_man;

    logic [COEF_W-1:0] b_arr [N_TAPS];
    assign b_arr[0]  = bus.FIR_B0;
    assign b_arr[1]  = bus.FIR_B1;
    assign b_arr[2]  = bus.FIR_B2;
    assign b_arr[3]  = bus.FIR_B3;
    assign b_arr[4]  = bus.FIR_B4;
    assign b_arr[5]  = bus.FIR_B5;
    assign b_arr[6]  = bus.FIR_B6;
    assign b_arr[7]  = bus.FIR_B7;
    assign b_arr[8]  = bus.FIR_B8;
    assign b_arr[9]  = bus.FIR_B9;
    assign b_arr[10] = bus.FIR_B10;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                edge_n;
    } vin_t;

    vin_t vin_q[$];
    int   done_q[$];
    int   err_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   vout_total = 0;
    int   vout_limit = 0;

    always @(posedge CLK) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Filter stand-in: one FIR_VOUT per FIR_VIN, one cycle later, up to a limit.
    always @(negedge CLK) begin
        if ((bus.FIR_VIN === 1'b1) && (vout_total < vout_limit)) begin
            vout_model <= 1'b1;
            vout_total <= vout_total + 1;
        end else begin
            vout_model <= 1'b0;
        end
    end

    // Monitor: every observed event must match the head of its queue.
    always @(negedge CLK) begin : mon
        vin_t e;
        int   d;
        if (bus.FIR_VIN === 1'b1) begin
            chk("FIR_VIN expected", vin_q.size() > 0, 1);
            if (vin_q.size() > 0) begin
                e = vin_q.pop_front();
                chk("FIR_DIN", bus.FIR_DIN, e.data);
                chk("FIR_VIN edge", edge_n, e.edge_n);
            end
        end
        if (bus.DONE === 1'b1) begin
            chk("DONE expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) begin
                d = done_q.pop_front();
                chk("DONE edge", edge_n, d);
            end
        end
        if (bus.CFG_ERR === 1'b1) begin
            chk("CFG_ERR expected", err_q.size() > 0, 1);
            if (err_q.size() > 0) begin
                d = err_q.pop_front();
                chk("CFG_ERR edge", edge_n, d);
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    // Called at a falling edge; the write is sampled on the next rising edge.
    task automatic cfg_write(input int a, input int d, input bit exp_err);
        logic [31:0] av, dv;
        av = a;
        dv = d;
        bus.CFG_WE   = 1'b1;
        bus.CFG_ADDR = av[ADDR_W-1:0];
        bus.CFG_DATA = dv[COEF_W-1:0];
        if (exp_err) err_q.push_back(edge_n + 1);
        tick();
        bus.CFG_WE = 1'b0;
    endtask

    // START a frame and stream n_drive samples back to back.
    task automatic run_frame(input int len, input int n_drive, input bit wr_in_run,
                             output int s_edge);
        vin_t e;
        logic [31:0] lv;
        lv = len;
        bus.FRAME_LEN = lv[FW-1:0];
        bus.START     = 1'b1;
        s_edge        = edge_n + 1;
        tick();
        bus.START = 1'b0;
        for (int k = 1; k <= n_drive; k++) begin
            chk("SRC_RDY high in RUN", bus.SRC_RDY, 1);
            bus.SRC_VIN = 1'b1;
            bus.SRC_DIN = 16'h1234 * 16'(k) ^ 16'h5A00;
            e.data   = bus.SRC_DIN;
            e.edge_n = s_edge + k;
            vin_q.push_back(e);
            if (wr_in_run && k == 2) begin
                bus.CFG_WE   = 1'b1;
                bus.CFG_ADDR = 4'd3;
                bus.CFG_DATA = 9'h155;
                err_q.push_back(s_edge + k);
            end
            tick();
            bus.CFG_WE = 1'b0;
        end
        bus.SRC_VIN = 1'b0;
        if (n_drive == len) begin
            chk("SRC_RDY low after last", bus.SRC_RDY, 0);
            for (int j = 1; j <= FL; j++) begin
                e.data   = '0;
                e.edge_n = s_edge + len + j;
                vin_q.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((done_q.size() != 0 || vin_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk({nm, " finished within budget"}, n < 300, 1);
        tick();
    endtask

    initial begin : stim
        int s, l;
        bus.CFG_WE = 1'b0; bus.CFG_ADDR = '0; bus.CFG_DATA = '0;
        bus.START = 1'b0; bus.FRAME_LEN = '0;
        bus.SRC_DIN = '0; bus.SRC_VIN = 1'b0;
        tick(); tick();
        chk("reset BUSY", bus.BUSY, 0);
        chk("reset SRC_RDY", bus.SRC_RDY, 0);
        chk("reset FIR_VIN", bus.FIR_VIN, 0);
        chk("reset FIR_DIN", bus.FIR_DIN, 0);
        chk("reset TIMEOUT", bus.TIMEOUT, 0);
        chk("reset FIR_B5", b_arr[5], 0);
        RST_n = 1'b1;
        tick();

        // Coefficient load: B[n] = 0x0A + n.
        for (int n = 0; n < N_TAPS; n++) cfg_write(n, 10 + n, 1'b0);
        tick();
        for (int n = 0; n < N_TAPS; n++) chk($sformatf("FIR_B%0d", n), b_arr[n], 10 + n);

        // Illegal address in IDLE.
        cfg_write(12, 9'h1FF, 1'b1);
        tick();
        for (int n = 0; n < N_TAPS; n++) chk($sformatf("FIR_B%0d after bad addr", n), b_arr[n], 10 + n);

        // FRAME_LEN=5, every sample echoed by the filter; one write during RUN.
        vout_limit = vout_total + 5 + FL;
        run_frame(5, 5, 1'b1, s);
        done_q.push_back(s + 5 + FL + 1);
        wait_done("frame len5");
        chk("TIMEOUT after len5", bus.TIMEOUT, 0);
        chk("FIR_B3 after RUN write", b_arr[3], 13);
        chk("BUSY after len5", bus.BUSY, 0);

        // FRAME_LEN=4, only two outputs: drain timeout; START in DRAIN ignored.
        vout_limit = vout_total;
        run_frame(4, 4, 1'b0, s);
        vout_man = 1'b1;
        tick(); tick();
        vout_man = 1'b0;
        l = edge_n;
        done_q.push_back(l + 64);
        tick(); tick(); tick();
        bus.FRAME_LEN = '0;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        chk("BUSY in DRAIN", bus.BUSY, 1);
        wait_done("timeout frame");
        chk("TIMEOUT set", bus.TIMEOUT, 1);
        chk("BUSY after timeout", bus.BUSY, 0);

        // FRAME_LEN=0: DONE right after START; also clears TIMEOUT.
        bus.FRAME_LEN = '0;
        bus.START = 1'b1;
        done_q.push_back(edge_n + 1);
        tick();
        bus.START = 1'b0;
        chk("TIMEOUT cleared by START", bus.TIMEOUT, 0);
        chk("SRC_RDY len0", bus.SRC_RDY, 0);
        chk("BUSY len0 DONE state", bus.BUSY, 1);
        tick();
        chk("SRC_RDY len0 after", bus.SRC_RDY, 0);
        chk("BUSY len0 after", bus.BUSY, 0);
        chk("DONE queue len0", done_q.size(), 0);

`ifdef FIR_SEQ_CTRL_FLUSH_EN
        // FRAME_LEN=3 with flush: 14 samples into the filter, DONE after 14 outputs.
        vout_limit = vout_total + 14;
        run_frame(3, 3, 1'b0, s);
        done_q.push_back(s + 15);
        wait_done("flush len3");
        chk("TIMEOUT after flush", bus.TIMEOUT, 0);
`endif

        // Reset in the middle of RUN after three samples.
        vout_limit = vout_total;
        run_frame(8, 3, 1'b0, s);
        #2 RST_n = 1'b0;
        #1;
        chk("midrst BUSY", bus.BUSY, 0);
        chk("midrst SRC_RDY", bus.SRC_RDY, 0);
        chk("midrst FIR_VIN", bus.FIR_VIN, 0);
        chk("midrst FIR_DIN", bus.FIR_DIN, 0);
        chk("midrst DONE", bus.DONE, 0);
        chk("midrst FIR_B0", b_arr[0], 0);
        chk("midrst FIR_B10", b_arr[10], 0);
        tick(); tick();
        RST_n = 1'b1;
        repeat (80) tick();
        chk("midrst BUSY after", bus.BUSY, 0);

        chk("VIN queue empty", vin_q.size(), 0);
        chk("DONE queue empty", done_q.size(), 0);
        chk("CFG_ERR queue empty", err_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
